// File: rtl/rv16_hazard_ctrl_if.sv
// Handshake bundle between the rv16 datapath (master) and the hazard/forwarding controller (slave).
// Carries the ID-stage tag, EX/branch status, and the stall/flush/forward controls.
interface rv16_hazard_ctrl_if #(
  parameter int unsigned RA_W  = 4,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SEL_W = $clog2(DEPTH)
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [RA_W-1:0] id_rd;
  logic            id_regwrite;
  logic            id_is_load;
  logic            ex_busy;
  logic            br_taken;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             ex_kill;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [DEPTH-1:0] stage_valid;
  logic [15:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_regwrite, id_is_load, ex_busy, br_taken,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_kill,
           fwd_a_sel, fwd_b_sel, stage_valid, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_regwrite, id_is_load, ex_busy, br_taken,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_kill,
           fwd_a_sel, fwd_b_sel, stage_valid, stall_cnt
  );
endinterface

// File: rtl/rv16_hazard_ctrl.sv
// rv16 hazard/forwarding controller: tracks rd tags from EX to WB and drives forwarding,
// load-use stall, branch flush and multi-cycle EX hold. Define ZERO_REG_EN to hardwire r0 to zero.
module rv16_hazard_ctrl #(
  parameter int unsigned RA_W       = 4,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned BR_STAGE   = 1,
  parameter int unsigned SEL_W      = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  rv16_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ADV_SHIFT,
    ADV_LOADUSE,
    ADV_BUSY,
    ADV_FLUSH
  } adv_t;

  localparam logic BR_LATE = (BR_STAGE > 0);

  logic [DEPTH-1:0] st_v, st_we, st_ld;
  logic [RA_W-1:0]  st_rd [DEPTH];
  logic [RA_W-1:0]  ex_rs1, ex_rs2;
  logic             ex_u1, ex_u2;

  logic [DEPTH-1:0] nx_v, nx_we, nx_ld;
  logic [RA_W-1:0]  nx_rd [DEPTH];
  logic [RA_W-1:0]  nx_rs1, nx_rs2;
  logic             nx_u1, nx_u2;

  logic [DEPTH-1:0] bub;
  logic [15:0]      stall_q;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             lu, fl, hold, on;
  logic             unused_tags;
  adv_t             adv;

  function automatic logic tag_match(input logic v, input logic we,
                                     input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r);
`ifdef ZERO_REG_EN
    return v && we && (rd == r) && (rd != '0);
`else
    return v && we && (rd == r);
`endif
  endfunction

  // Scan from WB towards stage 1 so the youngest producer is written last and wins.
  always_comb begin : fwd_sel
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (ex_u1 && tag_match(st_v[DEPTH-i], st_we[DEPTH-i], st_rd[DEPTH-i], ex_rs1))
        sel_a = SEL_W'(DEPTH - i);
      if (ex_u2 && tag_match(st_v[DEPTH-i], st_we[DEPTH-i], st_rd[DEPTH-i], ex_rs2))
        sel_b = SEL_W'(DEPTH - i);
    end
  end

  // Only loads that cannot yet forward their data (stages before LOAD_STAGE-1) force a stall.
  always_comb begin : load_use
    lu = 1'b0;
    for (int unsigned k = 0; k + 2 <= LOAD_STAGE; k++) begin
      if (st_ld[k] &&
          ((hz.id_uses_rs1 && tag_match(st_v[k], st_we[k], st_rd[k], hz.id_rs1)) ||
           (hz.id_uses_rs2 && tag_match(st_v[k], st_we[k], st_rd[k], hz.id_rs2))))
        lu = 1'b1;
    end
    lu = lu && hz.id_valid;
  end

  assign fl   = hz.br_taken;
  assign hold = (lu | hz.ex_busy) & ~fl;

  always_comb begin : adv_mode
    adv = ADV_SHIFT;
    if (fl)              adv = ADV_FLUSH;
    else if (hz.ex_busy) adv = ADV_BUSY;
    else if (lu)         adv = ADV_LOADUSE;
  end

  always_comb begin : bubble_mask
    bub = '0;
    unique case (adv)
      ADV_FLUSH: begin
        for (int unsigned k = 0; k < DEPTH; k++)
          if (k <= BR_STAGE) bub[k] = 1'b1;
      end
      ADV_BUSY:    bub[1] = 1'b1;
      ADV_LOADUSE: bub[0] = 1'b1;
      default:     bub = '0;
    endcase
  end

  // Default is shift with stage 0 holding; stage 0 takes the ID tag only on a plain advance,
  // then the bubble mask overrides whichever stages must be emptied.
  always_comb begin : advance
    nx_v[0]  = st_v[0];
    nx_we[0] = st_we[0];
    nx_ld[0] = st_ld[0];
    nx_rd[0] = st_rd[0];
    nx_rs1   = ex_rs1;
    nx_rs2   = ex_rs2;
    nx_u1    = ex_u1;
    nx_u2    = ex_u2;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      nx_v[k]  = st_v[k-1];
      nx_we[k] = st_we[k-1];
      nx_ld[k] = st_ld[k-1];
      nx_rd[k] = st_rd[k-1];
    end
    if (adv == ADV_SHIFT) begin
      nx_v[0]  = hz.id_valid;
      nx_we[0] = hz.id_regwrite;
      nx_ld[0] = hz.id_is_load;
      nx_rd[0] = hz.id_rd;
      nx_rs1   = hz.id_rs1;
      nx_rs2   = hz.id_rs2;
      nx_u1    = hz.id_uses_rs1;
      nx_u2    = hz.id_uses_rs2;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bub[k]) begin
        nx_v[k]  = 1'b0;
        nx_we[k] = 1'b0;
        nx_ld[k] = 1'b0;
        nx_rd[k] = '0;
      end
    end
    if (bub[0]) begin
      nx_rs1 = '0;
      nx_rs2 = '0;
      nx_u1  = 1'b0;
      nx_u2  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_v    <= '0;
      st_we   <= '0;
      st_ld   <= '0;
      st_rd   <= '{default: '0};
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_u1   <= 1'b0;
      ex_u2   <= 1'b0;
      stall_q <= '0;
    end else begin
      st_v   <= nx_v;
      st_we  <= nx_we;
      st_ld  <= nx_ld;
      st_rd  <= nx_rd;
      ex_rs1 <= nx_rs1;
      ex_rs2 <= nx_rs2;
      ex_u1  <= nx_u1;
      ex_u2  <= nx_u2;
      if (hold && (stall_q != '1))
        stall_q <= stall_q + 16'd1;
    end
  end

  // Load flags beyond the stall window are carried for completeness but never consulted.
  assign unused_tags = ^st_ld;

  assign on             = ~rst;
  assign hz.pc_hold     = on & hold;
  assign hz.ifid_hold   = on & hold;
  assign hz.ifid_flush  = on & fl;
  assign hz.idex_bubble = on & (fl | (lu & ~hz.ex_busy));
  assign hz.ex_kill     = on & fl & hz.ex_busy & BR_LATE;
  assign hz.fwd_a_sel   = on ? sel_a : '0;
  assign hz.fwd_b_sel   = on ? sel_b : '0;
  assign hz.stage_valid = st_v;
  assign hz.stall_cnt   = stall_q;

endmodule

// File: tb/tb_rv16_hazard_ctrl.sv
// Directed bench for rv16_hazard_ctrl at default parameters (DEPTH=3, LOAD_STAGE=2, BR_STAGE=1).
module tb_rv16_hazard_ctrl;
  localparam int unsigned RA_W  = 4;
  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  rv16_hazard_ctrl_if #(.RA_W(RA_W), .DEPTH(DEPTH)) hz ();

  rv16_hazard_ctrl #(
    .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_STAGE(2), .BR_STAGE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input int unsigned pc, input int unsigned fl,
                         input int unsigned bub, input int unsigned kill);
    chk($sformatf("%s.pc_hold", tag),     32'(hz.pc_hold),     pc);
    chk($sformatf("%s.ifid_hold", tag),   32'(hz.ifid_hold),   pc);
    chk($sformatf("%s.ifid_flush", tag),  32'(hz.ifid_flush),  fl);
    chk($sformatf("%s.idex_bubble", tag), 32'(hz.idex_bubble), bub);
    chk($sformatf("%s.ex_kill", tag),     32'(hz.ex_kill),     kill);
  endtask

  task automatic set_id(input logic v, input logic [RA_W-1:0] rs1, input logic u1,
                        input logic [RA_W-1:0] rs2, input logic u2,
                        input logic [RA_W-1:0] rd, input logic we, input logic ld);
    hz.id_valid    = v;
    hz.id_rs1      = rs1;
    hz.id_uses_rs1 = u1;
    hz.id_rs2      = rs2;
    hz.id_uses_rs2 = u2;
    hz.id_rd       = rd;
    hz.id_regwrite = we;
    hz.id_is_load  = ld;
  endtask

  task automatic idle();
    set_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset with branch and busy asserted: every control must stay low
    rst = 1'b1;
    idle();
    hz.ex_busy  = 1'b1;
    hz.br_taken = 1'b1;
    #3;
    chk_ctl("rst_pre", 0, 0, 0, 0);
    tick();
    chk("rst.stage_valid", 32'(hz.stage_valid), 0);
    chk("rst.stall_cnt", 32'(hz.stall_cnt), 0);
    chk_ctl("rst_post", 0, 0, 0, 0);
    rst = 1'b0;
    hz.ex_busy  = 1'b0;
    hz.br_taken = 1'b0;

    // back-to-back ALU forwarding
    set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0);
    #1;
    chk_ctl("t1_issue", 0, 0, 0, 0);
    tick();
    set_id(1, 4'd3, 1, 4'd5, 1, 4'd4, 1, 0);
    #1;
    chk_ctl("t1_dep", 0, 0, 0, 0);
    tick();
    chk("t1.fwd_a_ex1", 32'(hz.fwd_a_sel), 1);
    chk("t1.fwd_b_none", 32'(hz.fwd_b_sel), 0);
    set_id(1, 4'd3, 1, 4'd4, 1, 4'd6, 1, 0);
    tick();
    chk("t1.fwd_a_wb", 32'(hz.fwd_a_sel), 2);
    chk("t1.fwd_b_ex1", 32'(hz.fwd_b_sel), 1);
    chk("t1.stage_valid", 32'(hz.stage_valid), 3'b111);

    // two producers of r7 in flight: the younger one must win
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0);
    tick();
    tick();
    set_id(1, 4'd7, 1, 4'd7, 1, 4'd8, 1, 0);
    tick();
    chk("t1.young_a", 32'(hz.fwd_a_sel), 1);
    chk("t1.young_b", 32'(hz.fwd_b_sel), 1);
    chk("t1.stall_cnt", 32'(hz.stall_cnt), 0);
    idle();
    tick();
    tick();
    tick();

    // load-use on rs2: one stall cycle, then forward from WB
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1);
    tick();
    set_id(1, 4'd9, 1, 4'd2, 1, 4'd8, 1, 0);
    #1;
    chk_ctl("t2_stall", 1, 0, 1, 0);
    tick();
    chk_ctl("t2_after", 0, 0, 0, 0);
    chk("t2.stall_cnt", 32'(hz.stall_cnt), 1);
    chk("t2.stage_valid", 32'(hz.stage_valid), 3'b010);
    tick();
    chk("t2.fwd_b_wb", 32'(hz.fwd_b_sel), 2);
    chk("t2.fwd_a_none", 32'(hz.fwd_a_sel), 0);

    // same hazard with rs2 as immediate: no stall, no forward
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1);
    tick();
    set_id(1, 4'd9, 1, 4'd2, 0, 4'd8, 1, 0);
    #1;
    chk_ctl("t3_nostall", 0, 0, 0, 0);
    tick();
    chk("t3.fwd_b_imm", 32'(hz.fwd_b_sel), 0);
    chk("t3.fwd_a_none", 32'(hz.fwd_a_sel), 0);
    chk("t3.stall_cnt", 32'(hz.stall_cnt), 1);
    idle();
    tick();
    tick();
    tick();

    // branch taken while a load-use stall is pending
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1);
    tick();
    set_id(1, 4'd2, 1, 4'd0, 0, 4'd11, 1, 0);
    hz.br_taken = 1'b1;
    #1;
    chk_ctl("t4_flush", 0, 1, 1, 0);
    tick();
    hz.br_taken = 1'b0;
    chk("t4.stage_valid", 32'(hz.stage_valid), 0);
    chk("t4.stall_cnt", 32'(hz.stall_cnt), 1);
    idle();
    tick();

    // multi-cycle EX held four cycles with a dependent instruction in ID
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0);
    tick();
    set_id(1, 4'd5, 1, 4'd0, 0, 4'd10, 1, 0);
    hz.ex_busy = 1'b1;
    #1;
    chk_ctl("t5_busy0", 1, 0, 0, 0);
    tick();
    chk("t5.stage_valid_busy", 32'(hz.stage_valid), 3'b001);
    for (int i = 1; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("t5_busy%0d", i), 1, 0, 0, 0);
      tick();
    end
    hz.ex_busy = 1'b0;
    #1;
    chk_ctl("t5_release", 0, 0, 0, 0);
    chk("t5.stall_cnt", 32'(hz.stall_cnt), 5);
    tick();
    chk("t5.fwd_a_mul", 32'(hz.fwd_a_sel), 1);
    chk("t5.stage_valid", 32'(hz.stage_valid), 3'b011);

    // r0 as producer and consumer
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0);
    tick();
    set_id(1, 4'd0, 1, 4'd0, 0, 4'd12, 1, 0);
    tick();
`ifdef ZERO_REG_EN
    chk("t5.r0_fwd", 32'(hz.fwd_a_sel), 0);
`else
    chk("t5.r0_fwd", 32'(hz.fwd_a_sel), 1);
`endif
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 1);
    tick();
    set_id(1, 4'd0, 1, 4'd0, 0, 4'd12, 1, 0);
    #1;
`ifdef ZERO_REG_EN
    chk("t5.r0_loaduse", 32'(hz.pc_hold), 0);
`else
    chk("t5.r0_loaduse", 32'(hz.pc_hold), 1);
`endif
    idle();
    tick();
    tick();
    tick();

    // branch kills a busy multi-cycle op
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0);
    tick();
    set_id(1, 4'd5, 1, 4'd0, 0, 4'd10, 1, 0);
    hz.ex_busy  = 1'b1;
    hz.br_taken = 1'b1;
    #1;
    chk_ctl("kill", 0, 1, 1, 1);
    tick();
    hz.ex_busy  = 1'b0;
    hz.br_taken = 1'b0;
    chk("kill.stage_valid", 32'(hz.stage_valid), 0);
    idle();
    tick();

    // reset in the middle of a busy stall
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0);
    tick();
    set_id(1, 4'd5, 1, 4'd0, 0, 4'd10, 1, 0);
    hz.ex_busy = 1'b1;
    tick();
    #1;
    chk("t6.pre_hold", 32'(hz.pc_hold), 1);
    rst = 1'b1;
    #1;
    chk_ctl("t6_rst", 0, 0, 0, 0);
    tick();
    chk_ctl("t6_rst_edge", 0, 0, 0, 0);
    chk("t6.rst_stage_valid", 32'(hz.stage_valid), 0);
    chk("t6.rst_stall_cnt", 32'(hz.stall_cnt), 0);
    rst = 1'b0;
    hz.ex_busy = 1'b0;
    idle();
    #1;
    chk_ctl("t6_release", 0, 0, 0, 0);
    tick();
    chk("t6.stage_valid", 32'(hz.stage_valid), 0);
    chk("t6.stall_cnt", 32'(hz.stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv16_hazard_ctrl.md
Name: rv16_hazard_ctrl

Overview:
Parametrised pipeline hazard and forwarding controller for the rv16 core family. It tracks destination-register tags of every in-flight instruction from EX to WB and generates the following:
- forwarding selects for both EX operands;
- load-use stalls;
- branch flushes;
- multi-cycle EX hold, for divider or multiplier units.

It sits beside the datapath and replaces ad-hoc stall/flush logic. Pipeline depth, load latency and branch-resolve stage are generics rather than fixed at 5 stages.

Parameters:
RA_W, 4, register address width.
DEPTH, 3, tracked stages after ID; stage 0 = EX, DEPTH-1 = WB; legal range 2..8.
LOAD_STAGE, 2, first stage index whose result carries load data; 1 <= LOAD_STAGE <= DEPTH-1.
BR_STAGE, 1, stage index where br_taken is resolved; 0 <= BR_STAGE <= DEPTH-2.
SEL_W, $clog2(DEPTH), forwarding select width (derived; do not override).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  valid instruction in IF/ID
id_rs1, id_rs2  in  RA_W each  source register addresses
id_uses_rs1, id_uses_rs2  in  1 each  operand is a register (0 = immediate or unused)
id_rd  in  RA_W  destination register
id_regwrite  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
ex_busy  in  1  multi-cycle unit in stage 0 not finished
br_taken  in  1  instruction in stage BR_STAGE is a taken branch
pc_hold  out  1  PC keeps its value
ifid_hold  out  1  IF/ID register keeps its value
ifid_flush  out  1  IF/ID loads a bubble (all zeros)
idex_bubble  out  1  stage 0 loads a bubble
ex_kill  out  1  abort the multi-cycle operation in stage 0
fwd_a_sel, fwd_b_sel  out  SEL_W each  0 = register-file/latched value; k = result of stage k
stage_valid  out  DEPTH  valid bit per tracked stage
stall_cnt  out  16  saturating count of cycles with pc_hold=1

Behaviour:
- State held per stage k: valid, rd, regwrite, is_load. Stage 0 additionally holds rs1, rs2, uses_rs1, uses_rs2.
- Reset (rst=1 at posedge): all tags invalid, all fields 0, stall_cnt=0. While rst=1 every combinational output is forced to 0.
- Match(k, r) is defined as: stage k valid AND regwrite AND rd == r.
- Forwarding (combinational, for stage 0 operands):
  - fwd_a_sel = smallest k in 1..DEPTH-1 with uses_rs1 and Match(k, rs1); else 0.
  - fwd_b_sel is the same, using rs2 and uses_rs2.
  - Youngest producer wins.
  - A match on stage DEPTH-1 (WB) still forwards, covering the same-cycle regfile write.
- Load-use stall (lu):
  - Asserted when id_valid, and a stage k in 0..LOAD_STAGE-2 holds a load with Match(k, id_rs1 & uses_rs1) or Match(k, id_rs2 & uses_rs2).
  - With the defaults this means a load in EX whose rd matches an ID source.
- Flush (fl) = br_taken.
- Output equations:
  - pc_hold = ifid_hold = (lu | ex_busy) & ~fl
  - ifid_flush = fl
  - idex_bubble = fl | (lu & ~ex_busy)
  - ex_kill = fl & ex_busy & (BR_STAGE > 0)
- Tag advance at each posedge (rst=0):
  - fl=1: stages 0..BR_STAGE load bubbles. Stages > BR_STAGE shift (stage k gets stage k-1), so the branch itself moves on to BR_STAGE+1.
  - else ex_busy=1: stage 0 holds, stage 1 loads a bubble, stages >= 2 shift.
  - else lu=1: stage 0 loads a bubble, stages >= 1 shift.
  - else: stage 0 loads the ID tag (valid = id_valid), stages >= 1 shift.
- Stage DEPTH-1 content is discarded on every advance.
- Priority: fl > ex_busy > lu. A branch is always older than stage 0, so it may kill a busy EX op.
- stall_cnt increments when pc_hold=1 and saturates at 16'hFFFF.

Optional Feature:
ZERO_REG_EN
- Defined: register address 0 is hardwired zero. A tag with rd==0 never produces Match, so there is no forward and no load-use stall on r0.
- Undefined: r0 is an ordinary register, matching the rv16 register bank.

Test Plan:
1. Defaults; ADD r3 then ADD r4,r3,r5 back-to-back -> second instr in EX sees fwd_a_sel=1; the next cycle, an instr reading r3 sees fwd_a_sel=2; no stall.
2. LOAD r2 in EX, ID reads r2 via rs2 -> pc_hold=ifid_hold=idex_bubble=1 for exactly 1 cycle, then fwd_b_sel=2; stall_cnt=1.
3. Same as test 2 but id_uses_rs2=0 (immediate) -> no stall and fwd_b_sel=0.
4. br_taken=1 while a load-use stall is pending -> ifid_flush=1, pc_hold=0, and stage_valid[1:0]=00 next cycle.
5. ex_busy held 4 cycles with a dependent instr in ID -> pc_hold=1 for 4 cycles, stage_valid[1]=0 after the first, stall_cnt=4; with ZERO_REG_EN, a producer with rd=0 followed by a reader of r0 -> fwd_a_sel=0.
6. Reset asserted mid-stall with ex_busy=1 -> all outputs 0 during rst, stage_valid=0 and stall_cnt=0 after release.
